// File: rtl/wait_pkg.sv
// Shared types and defaults for the multi-channel wait timer.
package wait_pkg;

   localparam int unsigned DefNCh   = 4;
   localparam int unsigned DefTickW = 8;

   typedef logic [DefTickW-1:0] tick_t;

   typedef enum logic {
      StIdle,
      StRun
   } wait_state_e;

endpackage

// File: rtl/wait_channel.sv
// One delay channel: counts down a latched interval and pulses out on expiry.
module wait_channel
   import wait_pkg::*;
#(
   parameter int unsigned TICK_W = DefTickW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              periodic,
   input  logic [TICK_W-1:0] tick,
   output logic              out,
   output logic              busy
);

   wait_state_e       state_q, state_d;
   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic [TICK_W-1:0] reload_q, reload_d;
   logic              mode_q, mode_d;
   logic              out_q, out_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      out_d    = 1'b0;
      if (stop) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         if (state_q == StRun) begin
            if (cnt_q == TICK_W'(1)) begin
               out_d = 1'b1;
               if (mode_q) begin
                  cnt_d = reload_q;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - TICK_W'(1);
            end
         end
         // A start on the expiry edge keeps the pulse above and opens a new interval.
         if (start && (tick != '0)) begin
            cnt_d    = tick;
            reload_d = tick;
            mode_d   = periodic;
            state_d  = StRun;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         out_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         out_q    <= out_d;
      end
   end

   assign out  = out_q;
   assign busy = (state_q == StRun);

endmodule

// File: rtl/multi_wait_timer.sv
// Bank of N_CH independent wait channels sharing a clock and reset.
module multi_wait_timer
   import wait_pkg::*;
#(
   parameter int unsigned N_CH   = DefNCh,
   parameter int unsigned TICK_W = DefTickW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        start,
   input  logic [N_CH-1:0]        stop,
   input  logic [N_CH-1:0]        periodic,
   input  logic [N_CH*TICK_W-1:0] tick,
   output logic [N_CH-1:0]        out,
   output logic [N_CH-1:0]        busy
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      wait_channel #(
         .TICK_W (TICK_W)
      ) u_channel (
         .clk      (clk),
         .reset    (reset),
         .start    (start[i]),
         .stop     (stop[i]),
         .periodic (periodic[i]),
         .tick     (tick[i*TICK_W +: TICK_W]),
         .out      (out[i]),
         .busy     (busy[i])
      );
   end

endmodule
